// File: rtl/quad_decoder_pkg.sv
// Shared types and defaults for the quadrature decoder: state encoding and debounce depth.
package quad_decoder_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // Each state is encoded as the filtered {A,B} pair it represents.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_t;

  function automatic quad_state_t cw_next(input quad_state_t s);
    case (s)
      S00:     return S01;
      S01:     return S11;
      S11:     return S10;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/quadrature_decoder_debounce_filter.sv
// One encoder channel: 2-flop synchronizer followed by a tick-driven debounce counter.
module debounce_filter
  import quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_enable,
  input  logic pin,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      filtered <= 1'b1;
      cnt      <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // The counter only moves on ticks; any agreeing tick restarts the run.
      if (sample_enable) begin
        if (sync2 == filtered) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          filtered <= sync2;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder with per-channel debounce; QUAD_DECODER_ERROR_EN enables the error pulse.
module quadrature_decoder
  import quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_enable,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic       count_up,
  output logic       count_down,
  output logic       error,
  output logic [1:0] state_dbg,
  output logic [1:0] filtered_dbg
);

  logic        filt_a;
  logic        filt_b;
  quad_state_t state;
  quad_state_t filt_state;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
    .clock         (clock),
    .reset         (reset),
    .sample_enable (sample_enable),
    .pin           (enc_a),
    .filtered      (filt_a)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
    .clock         (clock),
    .reset         (reset),
    .sample_enable (sample_enable),
    .pin           (enc_b),
    .filtered      (filt_b)
  );

  assign filt_state   = quad_state_t'({filt_a, filt_b});
  assign state_dbg    = state;
  assign filtered_dbg = {filt_a, filt_b};

`ifdef QUAD_DECODER_ERROR_EN
  logic err_q;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // The state always follows the filtered pair, so an illegal jump resynchronises.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S11;
      count_up   <= 1'b0;
      count_down <= 1'b0;
`ifdef QUAD_DECODER_ERROR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= filt_state;
      count_up   <= (filt_state == cw_next(state));
      count_down <= (state == cw_next(filt_state));
`ifdef QUAD_DECODER_ERROR_EN
      err_q      <= (filt_state == quad_state_t'(~state));
`endif
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder (DEBOUNCE_CYCLES=4); honours QUAD_DECODER_ERROR_EN.
module tb_quadrature_decoder;

`ifdef QUAD_DECODER_ERROR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sample_enable = 1'b1;
  logic       enc_a = 1'b1;
  logic       enc_b = 1'b1;
  logic       count_up;
  logic       count_down;
  logic       error;
  logic [1:0] state_dbg;
  logic [1:0] filtered_dbg;

  int errors = 0;
  int checks = 0;
  logic se_div = 1'b0;
  int div_cnt = 0;

  quadrature_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .sample_enable (sample_enable),
    .enc_a         (enc_a),
    .enc_b         (enc_b),
    .count_up      (count_up),
    .count_down    (count_down),
    .error         (error),
    .state_dbg     (state_dbg),
    .filtered_dbg  (filtered_dbg)
  );

  // Clock and tick generation
  always #5 clock = ~clock;

  always @(negedge clock) begin
    sample_enable = se_div ? (div_cnt == 0) : 1'b1;
    div_cnt = (div_cnt + 1) % 8;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Observe hold clocks; edge indices count from the pin/reset change.
  // exp_at is the edge after the 4th tick seen from edge 3 onwards.
  task automatic watch(input int hold, output int up_n, output int dn_n, output int er_n,
                       output int first_at, output int exp_at, output int both_n,
                       output int filt_chg);
    logic [1:0] f0;
    int ticks;
    f0 = filtered_dbg;
    ticks = 0;
    up_n = 0; dn_n = 0; er_n = 0; both_n = 0; filt_chg = 0;
    first_at = -1; exp_at = -1;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clock);
      if (i >= 3 && sample_enable === 1'b1) ticks++;
      if (ticks == 4 && exp_at < 0) exp_at = i + 1;
      #1;
      if (count_up === 1'b1) up_n++;
      if (count_down === 1'b1) dn_n++;
      if (error === 1'b1) er_n++;
      if (count_up === 1'b1 && count_down === 1'b1) both_n++;
      if ((count_up | count_down | error) === 1'b1 && first_at < 0) first_at = i;
      if (filtered_dbg !== f0) filt_chg++;
    end
  endtask

  task automatic step_check(input string tag, input logic a, input logic b, input int hold,
                            input int exp_up, input int exp_dn, input int exp_er,
                            input int exp_first);
    int up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg;
    @(posedge clock);
    #1;
    enc_a = a;
    enc_b = b;
    watch(hold, up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg);
    check({tag, "_up"}, up_n, exp_up);
    check({tag, "_down"}, dn_n, exp_dn);
    check({tag, "_err"}, er_n, exp_er);
    check({tag, "_both"}, both_n, 0);
    check({tag, "_latency"}, first_at, exp_first);
    check({tag, "_state"}, int'(state_dbg), int'({a, b}));
  endtask

  initial begin
    int up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg;
    int tot_up, tot_dn, tot_er;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_up", int'(count_up), 0);
    check("rst_down", int'(count_down), 0);
    check("rst_err", int'(error), 0);
    check("rst_state", int'(state_dbg), 3);
    check("rst_filtered", int'(filtered_dbg), 3);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rel_up", int'(count_up), 0);
    check("rel_down", int'(count_down), 0);
    check("rel_err", int'(error), 0);

    // Counter-clockwise {A,B}: 11->01->00->10->11
    step_check("ccw1", 1'b0, 1'b1, 10, 0, 1, 0, 7);
    step_check("ccw2", 1'b0, 1'b0, 10, 0, 1, 0, 7);
    step_check("ccw3", 1'b1, 1'b0, 10, 0, 1, 0, 7);
    step_check("ccw4", 1'b1, 1'b1, 10, 0, 1, 0, 7);

    // Clockwise {A,B}: 11->10->00->01->11
    step_check("cw1", 1'b1, 1'b0, 10, 1, 0, 0, 7);
    step_check("cw2", 1'b0, 1'b0, 10, 1, 0, 0, 7);
    step_check("cw3", 1'b0, 1'b1, 10, 1, 0, 0, 7);
    step_check("cw4", 1'b1, 1'b1, 10, 1, 0, 0, 7);

    // 3-clock glitch on A
    @(posedge clock);
    #1;
    enc_a = 1'b0;
    watch(3, up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg);
    tot_up = up_n; tot_dn = dn_n; tot_er = er_n;
    enc_a = 1'b1;
    check("glitch_filt_a", filt_chg, 0);
    watch(10, up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg);
    check("glitch_pulses", tot_up + tot_dn + tot_er + up_n + dn_n + er_n, 0);
    check("glitch_filt_b", filt_chg, 0);
    check("glitch_filtered", int'(filtered_dbg), 3);

    // Illegal double flip, then legal steps resume from the new state
    step_check("illegal", 1'b0, 1'b0, 10, 0, 0, ERR_EN, (ERR_EN != 0) ? 7 : -1);
    step_check("post_ill1", 1'b0, 1'b1, 10, 1, 0, 0, 7);
    step_check("post_ill2", 1'b1, 1'b1, 10, 1, 0, 0, 7);

    // Sparse ticks: one every 8 clocks
    se_div = 1'b1;
    repeat (5) @(posedge clock);
    @(posedge clock);
    #1;
    enc_a = 1'b1;
    enc_b = 1'b0;
    watch(48, up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg);
    check("div_up", up_n, 1);
    check("div_down", dn_n, 0);
    check("div_latency", first_at, exp_at);
    check("div_exp_valid", int'(exp_at > 7), 1);
    se_div = 1'b0;
    repeat (2) @(posedge clock);
    step_check("back11", 1'b1, 1'b1, 10, 0, 1, 0, 7);

    // Reset after 2 of 4 ticks discards progress
    @(posedge clock);
    #1;
    enc_a = 1'b0;
    watch(4, up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg);
    tot_up = up_n + dn_n + er_n;
    reset = 1'b1;
    watch(2, up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg);
    tot_up += up_n + dn_n + er_n;
    check("rstmid_pulses", tot_up, 0);
    check("rstmid_filtered", int'(filtered_dbg), 3);
    reset = 1'b0;
    watch(10, up_n, dn_n, er_n, first_at, exp_at, both_n, filt_chg);
    check("rstmid_down", dn_n, 1);
    check("rstmid_up", up_n, 0);
    check("rstmid_latency", first_at, 7);
    check("rstmid_state", int'(state_dbg), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
